// File: rtl/xbar_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : xbar_cfg_sched
// Purpose  : Configuration sequencer for a SIZE-port Benes crossbar. Accepts a
//            destination permutation, checks it is a bijection, presents it to
//            the ctrl-bit generator, stages the result in a shadow register and
//            commits it to the live crossbar only while no data beat is busy.
// Options  : XBAR_IDENT_FASTPATH_EN - identity permutations bypass the
//            generator and load an all-zero ctrl word straight after CHECK.
// Revision : 1.0
// ============================================================================
module xbar_cfg_sched #(
    parameter int  SIZE     = 32,
    parameter int  CBG_LAT  = 2,
    localparam int TAGWIDTH = $clog2(SIZE),
    localparam int STAGES   = 2*TAGWIDTH-1,
    localparam int BITWIDTH = STAGES*(SIZE/2),
    localparam int PERMW    = SIZE*TAGWIDTH
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [PERMW-1:0]    i_req_perm,
    output logic [PERMW-1:0]    o_cbg_perm,
    input  logic [BITWIDTH-1:0] i_cbg_ctrl,
    input  logic                i_xbar_busy,
    output logic [BITWIDTH-1:0] o_xbar_ctrl,
    output logic                o_cfg_commit,
    output logic [7:0]          o_cfg_epoch,
    output logic                o_cfg_err,
    output logic                o_shadow_full
);

    localparam int GENW = (CBG_LAT > 1) ? $clog2(CBG_LAT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_GEN   = 2'd2;
    localparam logic [1:0] ST_STALL = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [PERMW-1:0]    r_perm_q;
    logic [SIZE-1:0]     r_seen;
    logic [TAGWIDTH-1:0] r_k;
    logic [GENW-1:0]     r_gen_cnt;
    logic                r_err;

    logic [BITWIDTH-1:0] r_shadow;
    logic                r_shadow_full;
    logic [BITWIDTH-1:0] r_xbar;
    logic                r_commit;
    logic [7:0]          r_epoch;

    logic [TAGWIDTH-1:0] w_entry;
    logic                w_dup;
    logic                w_chk_last;
    logic                w_gen_last;
    logic                w_commit;
    logic                w_cap_ok;
    logic                w_capture;
    logic                w_cap_zero;
    logic                w_accept;
    logic                w_fast_ident;
    logic                w_stall_zero;

    assign w_entry    = r_perm_q[int'(r_k)*TAGWIDTH +: TAGWIDTH];
    assign w_dup      = r_seen[w_entry];
    assign w_chk_last = (r_k == TAGWIDTH'(SIZE-1));
    assign w_gen_last = (r_gen_cnt == GENW'(CBG_LAT-1));

    // A capture is legal when the shadow is empty or is being drained this edge
    assign w_commit = r_shadow_full & ~i_xbar_busy;
    assign w_cap_ok = ~r_shadow_full | ~i_xbar_busy;

`ifdef XBAR_IDENT_FASTPATH_EN
    logic r_ident;
    logic r_stall_zero;
    logic w_ident_now;

    assign w_ident_now = r_ident & (w_entry == r_k);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_ident      <= 1'b0;
            r_stall_zero <= 1'b0;
        end else if (w_accept) begin
            r_ident      <= 1'b1;
        end else if (r_state == ST_CHECK) begin
            r_ident      <= w_ident_now;
            r_stall_zero <= w_ident_now;
        end
    end

    assign w_fast_ident = w_ident_now;
    assign w_stall_zero = r_stall_zero;
`else
    assign w_fast_ident = 1'b0;
    assign w_stall_zero = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_dup) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chk_last) begin
                    if (w_fast_ident) w_state_nxt = w_cap_ok ? ST_IDLE : ST_STALL;
                    else              w_state_nxt = ST_GEN;
                end
            end
            ST_GEN: begin
                if (w_gen_last) w_state_nxt = w_cap_ok ? ST_IDLE : ST_STALL;
            end
            ST_STALL: begin
                if (w_cap_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_cap_zero  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                w_accept    = i_req_valid;
            end
            ST_CHECK: begin
                if (!w_dup && w_chk_last && w_fast_ident && w_cap_ok) begin
                    w_capture  = 1'b1;
                    w_cap_zero = 1'b1;
                end
            end
            ST_GEN: begin
                if (w_gen_last && w_cap_ok) w_capture = 1'b1;
            end
            ST_STALL: begin
                if (w_cap_ok) begin
                    w_capture  = 1'b1;
                    w_cap_zero = w_stall_zero;
                end
            end
            default: begin
                o_req_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_perm_q  <= '0;
            r_seen    <= '0;
            r_k       <= '0;
            r_gen_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_perm_q <= i_req_perm;
                r_seen   <= '0;
                r_k      <= '0;
            end
            if (r_state == ST_CHECK) begin
                r_seen[w_entry] <= 1'b1;
                r_k             <= r_k + 1'b1;
                r_gen_cnt       <= '0;
                r_err           <= w_dup;
            end
            if (r_state == ST_GEN) begin
                r_gen_cnt <= r_gen_cnt + 1'b1;
            end
        end
    end

    // On a same-edge commit+capture the live word takes the old shadow value
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_xbar        <= '0;
            r_commit      <= 1'b0;
            r_epoch       <= 8'd0;
        end else begin
            r_commit      <= w_commit;
            r_shadow_full <= w_capture | (r_shadow_full & ~w_commit);
            if (w_commit) begin
                r_xbar  <= r_shadow;
                r_epoch <= r_epoch + 8'd1;
            end
            if (w_capture) begin
                r_shadow <= w_cap_zero ? '0 : i_cbg_ctrl;
            end
        end
    end

    assign o_cbg_perm    = r_perm_q;
    assign o_xbar_ctrl   = r_xbar;
    assign o_cfg_commit  = r_commit;
    assign o_cfg_epoch   = r_epoch;
    assign o_cfg_err     = r_err;
    assign o_shadow_full = r_shadow_full;

endmodule

`default_nettype wire

// File: tb/tb_xbar_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_cfg_sched
// Purpose  : Self-checking bench for xbar_cfg_sched with a pipelined generator
//            stand-in and a queue-based commit/error reference model.
// Revision : 1.0
// ============================================================================
module tb_xbar_cfg_sched;

    localparam int SIZE    = 32;
    localparam int CBG_LAT = 2;
    localparam int TW      = $clog2(SIZE);
    localparam int BW      = (2*TW-1)*(SIZE/2);
    localparam int PW      = SIZE*TW;
`ifdef XBAR_IDENT_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_perm;
    logic [PW-1:0] cbg_perm;
    logic [BW-1:0] cbg_ctrl;
    logic          xbar_busy;
    logic [BW-1:0] xbar_ctrl;
    logic          cfg_commit;
    logic [7:0]    cfg_epoch;
    logic          cfg_err;
    logic          shadow_full;

    xbar_cfg_sched #(.SIZE(SIZE), .CBG_LAT(CBG_LAT)) u_dut (
        .i_clk         (clk),
        .i_nrst        (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_perm    (req_perm),
        .o_cbg_perm    (cbg_perm),
        .i_cbg_ctrl    (cbg_ctrl),
        .i_xbar_busy   (xbar_busy),
        .o_xbar_ctrl   (xbar_ctrl),
        .o_cfg_commit  (cfg_commit),
        .o_cfg_epoch   (cfg_epoch),
        .o_cfg_err     (cfg_err),
        .o_shadow_full (shadow_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic do_check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Stand-in ctrl generator: an arbitrary mixing function, CBG_LAT stages deep
    function automatic logic [BW-1:0] gen_hash(input logic [PW-1:0] p);
        return p[BW-1:0] ^ {p[PW-1 -: 16], p[BW-1:16]} ^ {9{16'hA5C3}};
    endfunction

    logic [BW-1:0] gen_pipe [CBG_LAT];
    always @(posedge clk) begin
        gen_pipe[0] <= gen_hash(cbg_perm);
        for (int i = 1; i < CBG_LAT; i++) gen_pipe[i] <= gen_pipe[i-1];
    end
    assign cbg_ctrl = gen_pipe[CBG_LAT-1];

    // Reference model
    logic [BW-1:0] exp_q [$];
    int exp_commits  = 0;
    int exp_errs     = 0;
    int seen_commits = 0;
    int seen_errs    = 0;
    bit busy_rand    = 1'b0;

    function automatic bit perm_ok(input logic [PW-1:0] p);
        int cnt [SIZE];
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < SIZE; i++) cnt[p[i*TW +: TW]]++;
        for (int i = 0; i < SIZE; i++) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [PW-1:0] perm_ident();
        logic [PW-1:0] p;
        for (int i = 0; i < SIZE; i++) p[i*TW +: TW] = TW'(i);
        return p;
    endfunction

    function automatic logic [PW-1:0] perm_shuffle();
        logic [PW-1:0] p;
        logic [TW-1:0] t;
        int j;
        p = perm_ident();
        for (int i = SIZE-1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = p[i*TW +: TW];
            p[i*TW +: TW] = p[j*TW +: TW];
            p[j*TW +: TW] = t;
        end
        return p;
    endfunction

    function automatic void model_accept(input logic [PW-1:0] p);
        if (perm_ok(p)) begin
            exp_q.push_back((FAST && p == perm_ident()) ? '0 : gen_hash(p));
            exp_commits++;
        end else begin
            exp_errs++;
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        exp_commits  = 0;
        exp_errs     = 0;
        seen_commits = 0;
        seen_errs    = 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_commit) begin
                seen_commits++;
                if (exp_q.size() == 0) do_check("commit_unexpected", 256'(cfg_commit), 256'(0));
                else                   do_check("commit_ctrl", 256'(xbar_ctrl), 256'(exp_q.pop_front()));
                do_check("commit_epoch", 256'(cfg_epoch), 256'(seen_commits[7:0]));
            end
            if (cfg_err) seen_errs++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_rand) xbar_busy = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [PW-1:0] p, input int max_cyc, output bit acc);
        acc = 1'b0;
        req_perm  = p;
        req_valid = 1'b1;
        for (int n = 0; n < max_cyc && !acc; n++) begin
            if (req_ready) begin
                tick();
                acc = 1'b1;
                model_accept(p);
            end else begin
                tick();
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_pulse(input bit want_err, input int max_cyc, output int e);
        e = 0;
        do begin
            tick();
            e++;
        end while (!(want_err ? cfg_err : cfg_commit) && e < max_cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        do_check({tag, "_xbar"},   256'(xbar_ctrl),   256'(0));
        do_check({tag, "_epoch"},  256'(cfg_epoch),   256'(0));
        do_check({tag, "_ready"},  256'(req_ready),   256'(1));
        do_check({tag, "_commit"}, 256'(cfg_commit),  256'(0));
        do_check({tag, "_err"},    256'(cfg_err),     256'(0));
        do_check({tag, "_full"},   256'(shadow_full), 256'(0));
        do_check({tag, "_perm"},   256'(cbg_perm),    256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] prev_p;
        bit            acc;
        int            e;
        int            n_acc;
        int            a;
        int            b;

        rst_n = 1'b0; req_valid = 1'b0; req_perm = '0; xbar_busy = 1'b0;
        repeat (3) tick();
        model_clear();
        rst_n = 1'b1;
        repeat (5) tick();
        check_reset_outputs("idle");

        // Reversal permutation, no backpressure
        for (int i = 0; i < SIZE; i++) p[i*TW +: TW] = TW'(SIZE-1-i);
        send(p, 10, acc);
        do_check("rev_accept", 256'(acc), 256'(1));
        wait_pulse(1'b0, 100, e);
        do_check("rev_latency", 256'(e), 256'(SIZE+CBG_LAT+1));
        do_check("rev_ctrl", 256'(xbar_ctrl), 256'(gen_hash(p)));
        do_check("rev_epoch", 256'(cfg_epoch), 256'(1));
        prev_p = p;

        // Duplicate at entries 3 and 7
        p = perm_ident();
        p[3*TW +: TW] = TW'(5);
        p[5*TW +: TW] = TW'(3);
        p[7*TW +: TW] = TW'(5);
        send(p, 10, acc);
        wait_pulse(1'b1, 100, e);
        do_check("dup_err_latency", 256'(e), 256'(8));
        do_check("dup_ready", 256'(req_ready), 256'(1));
        tick();
        do_check("dup_err_pulse", 256'(cfg_err), 256'(0));
        repeat (40) tick();
        do_check("dup_xbar_hold", 256'(xbar_ctrl), 256'(gen_hash(prev_p)));
        do_check("dup_err_count", 256'(seen_errs), 256'(exp_errs));
        do_check("dup_no_commit", 256'(seen_commits), 256'(exp_commits));

        // Busy held: first fills shadow, second stalls, third is refused
        xbar_busy = 1'b1;
        send(perm_shuffle(), 10, acc);
        send(perm_shuffle(), 100, acc);
        do_check("stall_accept2", 256'(acc), 256'(1));
        repeat (SIZE+CBG_LAT+5) tick();
        do_check("stall_full", 256'(shadow_full), 256'(1));
        do_check("stall_ready", 256'(req_ready), 256'(0));
        send(perm_shuffle(), 60, acc);
        do_check("stall_reject", 256'(acc), 256'(0));
        do_check("stall_hold", 256'(seen_commits), 256'(exp_commits-2));
        xbar_busy = 1'b0;
        wait_pulse(1'b0, 10, e);
        do_check("drain1", 256'(e), 256'(1));
        wait_pulse(1'b0, 10, e);
        do_check("drain2", 256'(e), 256'(1));
        do_check("stall_epoch", 256'(cfg_epoch), 256'(exp_commits[7:0]));

        // Identity permutation
        p = perm_ident();
        send(p, 10, acc);
        wait_pulse(1'b0, 100, e);
        do_check("ident_latency", 256'(e), FAST ? 256'(SIZE+1) : 256'(SIZE+CBG_LAT+1));
        do_check("ident_ctrl", 256'(xbar_ctrl), FAST ? 256'(0) : 256'(gen_hash(p)));

        // Reset while in GEN
        send(perm_shuffle(), 10, acc);
        repeat (SIZE) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_gen");
        model_clear();
        rst_n = 1'b1;
        repeat (60) tick();
        do_check("rst_no_commit", 256'(xbar_ctrl), 256'(0));
        do_check("rst_no_full", 256'(shadow_full), 256'(0));

        // Randomized mix under random backpressure
        busy_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            a = $urandom_range(0, 5);
            if (a == 0)      p = perm_ident();
            else             p = perm_shuffle();
            if (a == 1) begin
                a = $urandom_range(0, SIZE-1);
                b = (a + 1 + $urandom_range(0, SIZE-2)) % SIZE;
                p[a*TW +: TW] = p[b*TW +: TW];
            end
            repeat ($urandom_range(0, 3)) tick();
            send(p, 400, acc);
            do_check("rnd_accept", 256'(acc), 256'(1));
        end
        busy_rand = 1'b0;
        xbar_busy = 1'b0;
        repeat (100) tick();
        do_check("rnd_commits", 256'(seen_commits), 256'(exp_commits));
        do_check("rnd_errs", 256'(seen_errs), 256'(exp_errs));
        do_check("rnd_epoch", 256'(cfg_epoch), 256'(exp_commits[7:0]));

        // 256 commits wrap the epoch counter
        rst_n = 1'b0;
        tick();
        model_clear();
        rst_n = 1'b1;
        tick();
        n_acc = 0;
        for (int r = 0; r < 256; r++) begin
            send(perm_shuffle(), 200, acc);
            if (acc) n_acc++;
        end
        repeat (60) tick();
        do_check("wrap_accept", 256'(n_acc), 256'(256));
        do_check("wrap_commits", 256'(seen_commits), 256'(256));
        do_check("epoch_wrap", 256'(cfg_epoch), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
